// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run/pause/single-step clock-enable controller for the SAP-1 CPU.
// Define CPU_CLK_CTRL_DEBOUNCE_EN to add a stability-counter debouncer on both buttons.
module cpu_clk_ctrl #(
    parameter int DIV_WIDTH       = 21,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter bit START_RUN       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run_btn,
    input  logic i_step_btn,
    input  logic i_hlt,
    output logic o_cpu_en,
    output logic o_running,
    output logic o_halted,
    output logic o_heartbeat
);

    localparam logic [1:0] ST_PAUSED  = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_STEP    = 2'd2;
    localparam logic [1:0] ST_HALTED  = 2'd3;
    localparam logic [1:0] ST_INIT    = START_RUN ? ST_RUNNING : ST_PAUSED;

    logic [DIV_WIDTH-1:0] r_prescaler;
    logic                 r_heartbeat;
    logic                 w_tick;

    logic [1:0] w_rawBtn;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] w_level;
    logic [1:0] r_levelPrev;
    logic [1:0] r_press;
    logic       w_runPress;
    logic       w_stepPress;

    logic [1:0] r_state;
    logic       r_cpuEn;

    assign w_tick = &r_prescaler;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescaler <= '0;
            r_heartbeat <= 1'b0;
        end else begin
            r_prescaler <= r_prescaler + DIV_WIDTH'(1);
            if (w_tick) begin
                r_heartbeat <= ~r_heartbeat;
            end
        end
    end

    // Bit 0 is the run button, bit 1 the step button throughout the front end.
    assign w_rawBtn = {i_step_btn, i_run_btn};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_levelPrev <= '0;
            r_press     <= '0;
        end else begin
            r_sync1     <= w_rawBtn;
            r_sync2     <= r_sync1;
            r_levelPrev <= w_level;
            r_press     <= w_level & ~r_levelPrev;
        end
    end

`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
    localparam int                  DB_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_WIDTH-1:0] DB_LAST  = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [DB_WIDTH-1:0] r_dbCount [2];
    logic [1:0]          r_dbLevel;

    // Count consecutive samples that disagree with the debounced level; the counter
    // clears on any agreement and never runs past DB_LAST, so it cannot wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbLevel <= '0;
            for (int b = 0; b < 2; b++) begin
                r_dbCount[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (r_sync2[b] == r_dbLevel[b]) begin
                    r_dbCount[b] <= '0;
                end else if (r_dbCount[b] == DB_LAST) begin
                    r_dbLevel[b] <= r_sync2[b];
                    r_dbCount[b] <= '0;
                end else begin
                    r_dbCount[b] <= r_dbCount[b] + DB_WIDTH'(1);
                end
            end
        end
    end

    assign w_level = r_dbLevel;
`else
    assign w_level = r_sync2;
`endif

    assign w_runPress  = r_press[0];
    assign w_stepPress = r_press[1];

    // Halt beats a run press, which beats a step press or a prescaler tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_cpuEn <= 1'b0;
        end else begin
            r_cpuEn <= 1'b0;
            case (r_state)
                ST_RUNNING: begin
                    if (i_hlt) begin
                        r_state <= ST_HALTED;
                    end else if (w_runPress) begin
                        r_state <= ST_PAUSED;
                    end else if (w_tick) begin
                        r_cpuEn <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (i_hlt) begin
                        r_state <= ST_HALTED;
                    end else if (w_runPress) begin
                        r_state <= ST_RUNNING;
                    end else if (w_stepPress) begin
                        r_state <= ST_STEP;
                        r_cpuEn <= 1'b1;
                    end
                end
                ST_STEP: begin
                    r_state <= ST_PAUSED;
                end
                default: begin
                    r_state <= ST_HALTED;
                end
            endcase
        end
    end

    assign o_cpu_en    = r_cpuEn;
    assign o_running   = (r_state == ST_RUNNING);
    assign o_halted    = (r_state == ST_HALTED);
    assign o_heartbeat = r_heartbeat;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with DIV_WIDTH=4 (tick every 16 cycles) and START_RUN=1.
// Cycle 0 is the first cycle after reset release; raw inputs set in cycle N are sampled at its end.
module tb_cpu_clk_ctrl;

    localparam int DIV_WIDTH = 4;
    localparam int DEB       = 8;

    logic clk = 1'b0;
    logic reset;
    logic i_run_btn;
    logic i_step_btn;
    logic i_hlt;
    logic o_cpu_en;
    logic o_running;
    logic o_halted;
    logic o_heartbeat;

    int vectorCount = 0;
    int failCount   = 0;
    int cyc         = 0;

    always #5 clk = ~clk;

    cpu_clk_ctrl #(
        .DIV_WIDTH      (DIV_WIDTH),
        .DEBOUNCE_CYCLES(DEB),
        .START_RUN      (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_run_btn  (i_run_btn),
        .i_step_btn (i_step_btn),
        .i_hlt      (i_hlt),
        .o_cpu_en   (o_cpu_en),
        .o_running  (o_running),
        .o_halted   (o_halted),
        .o_heartbeat(o_heartbeat)
    );

    task automatic applyStimulus(input logic run, input logic step, input logic hlt);
        i_run_btn  = run;
        i_step_btn = step;
        i_hlt      = hlt;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Heartbeat has toggled once per 16-cycle tick since reset release, so it equals cyc bit 4.
    task automatic checkOutput(input string tag, input logic expEn, input logic expRun,
                               input logic expHalt);
        logic [3:0] obs;
        logic [3:0] exp;
        obs = {o_cpu_en, o_running, o_halted, o_heartbeat};
        exp = {expEn, expRun, expHalt, cyc[DIV_WIDTH]};
        vectorCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s cyc=%0d observed {en,run,halt,hb}=%b expected=%b",
                   tag, cyc, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("in_reset", 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        checkOutput("reset_values", 1'b0, 1'b1, 1'b0);

        // Free running: enables at 16 and 32.
        while (cyc < 40) begin
            nextCycle();
            checkOutput("run_period", (cyc == 16) || (cyc == 32), 1'b1, 1'b0);
        end

`ifndef CPU_CLK_CTRL_DEBOUNCE_EN
        // Run pulse in cycle 40 -> press in 43 -> PAUSED from 44; tick at 47 gives nothing.
        while (cyc < 60) begin
            applyStimulus(cyc == 40, 1'b0, 1'b0);
            nextCycle();
            checkOutput("pause", 1'b0, cyc <= 43, 1'b0);
        end

        // Three step pushes (held 3, 1 and 6 cycles) -> enables 4 cycles after each rise.
        while (cyc < 90) begin
            applyStimulus(1'b0, (cyc >= 60 && cyc <= 62) || (cyc == 70) || (cyc >= 80 && cyc <= 85),
                          1'b0);
            nextCycle();
            checkOutput("step", (cyc == 64) || (cyc == 74) || (cyc == 84), 1'b0, 1'b0);
        end

        // Run and step rise together in 90: run wins, RUNNING from 94, tick at 95 -> enable 96.
        while (cyc < 100) begin
            applyStimulus(cyc == 90, cyc == 90, 1'b0);
            nextCycle();
            checkOutput("simultaneous", cyc == 96, cyc >= 94, 1'b0);
        end

        // Halt, run press and tick all land in cycle 111; later buttons are ignored.
        while (cyc < 150) begin
            applyStimulus((cyc == 108) || (cyc == 115), cyc == 120, cyc == 111);
            nextCycle();
            checkOutput("halt", 1'b0, cyc <= 111, cyc >= 112);
        end

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        checkOutput("halt_reset_exit", 1'b0, 1'b1, 1'b0);
        while (cyc < 17) begin
            nextCycle();
            checkOutput("after_halt_reset", cyc == 16, 1'b1, 1'b0);
        end
`else
        // 20-cycle run push from 40 -> press in 51 -> PAUSED from 52; tick at 47 still enables.
        while (cyc < 60) begin
            applyStimulus(cyc >= 40 && cyc <= 59, 1'b0, 1'b0);
            nextCycle();
            checkOutput("db_pause", cyc == 48, cyc <= 51, 1'b0);
        end

        // Five-cycle step glitch never reaches the debounce threshold.
        while (cyc < 80) begin
            applyStimulus(1'b0, cyc >= 60 && cyc <= 64, 1'b0);
            nextCycle();
            checkOutput("db_glitch", 1'b0, 1'b0, 1'b0);
        end

        // 20-cycle step push from 80 -> press in 91 -> single enable in 92.
        while (cyc < 115) begin
            applyStimulus(1'b0, cyc >= 80 && cyc <= 99, 1'b0);
            nextCycle();
            checkOutput("db_step", cyc == 92, 1'b0, 1'b0);
        end

        // Run held from 115; debounce count reaches 4 in cycle 121, where reset hits.
        while (cyc < 121) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            nextCycle();
            checkOutput("db_count", 1'b0, 1'b0, 1'b0);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        cyc = 0;
        checkOutput("db_reset_values", 1'b0, 1'b1, 1'b0);
        while (cyc < 20) begin
            nextCycle();
            checkOutput("db_reset_abort", cyc == 16, 1'b1, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Run/pause/single-step clock-enable controller for the SAP-1 CPU on the icestick board. It sits between the 12 MHz board clock and the CPU. It generates a one-cycle CPU enable at a prescaled rate while running, one enable per step-button press while paused, and stops permanently when the CPU signals HLT. It also drives status LEDs for run, halt and heartbeat.

## Interface
- `DIV_WIDTH`, default 21: prescaler width. The tick period is 2^DIV_WIDTH clk cycles.
- `DEBOUNCE_CYCLES`, default 65536: number of consecutive stable cycles a button must hold before its debounced level changes. Used only when debounce is compiled in.
- `START_RUN`, default 1: state after reset. 1 = RUNNING, 0 = PAUSED.
- `clk`  in  1: board clock. This is the single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `i_run_btn`  in  1: raw run/pause button, active-high, asynchronous.
- `i_step_btn`  in  1: raw single-step button, active-high, asynchronous.
- `i_hlt`  in  1: HLT flag from the CPU, synchronous to clk.
- `o_cpu_en`  out  1: registered one-cycle clock enable to the CPU.
- `o_running`  out  1: high when state is RUNNING.
- `o_halted`  out  1: high when state is HALTED.
- `o_heartbeat`  out  1: toggles on every prescaler tick.

## Operation
- **Prescaler:** a free-running DIV_WIDTH-bit up-counter that wraps. `tick` is asserted for the single cycle in which the counter is all ones.
- **Button front end:** each button passes through a 2-flop synchroniser. A `press` pulse is a one-cycle pulse on the rising edge of the conditioned level (see Configuration).
- **FSM states:** PAUSED, RUNNING, STEP, HALTED.
- **RUNNING:**
  - `i_hlt` high → HALTED.
  - Otherwise, run press → PAUSED.
  - Otherwise, tick → `o_cpu_en` is asserted on the next cycle.
  - Step presses are ignored.
- **PAUSED:**
  - `i_hlt` high → HALTED.
  - Otherwise, run press → RUNNING.
  - Otherwise, step press → STEP.
  - If run and step presses occur in the same cycle, run wins and the step press is dropped.
- **STEP:** lasts exactly one cycle with `o_cpu_en` = 1, then returns unconditionally to PAUSED.
- **HALTED:**
  - `o_cpu_en` is held at 0.
  - Buttons are ignored.
  - Only `reset` exits this state.
- **Priority within one cycle:** `i_hlt` > run press > step press or tick.
- **Reset** clears the prescaler, synchroniser/debounce state and `o_heartbeat`.
  - State becomes RUNNING if START_RUN = 1, otherwise PAUSED.
  - Reset applied mid-step or mid-debounce aborts that operation with no `o_cpu_en` pulse.

## Timing
- **Reset values:**
  - `o_cpu_en` = 0.
  - `o_heartbeat` = 0.
  - `o_halted` = 0.
  - `o_running` = START_RUN.
- `o_cpu_en`, `o_running` and `o_halted` are all registered. None has a combinational path from inputs.
- **Run enable latency:** if tick occurs in cycle N in RUNNING, `o_cpu_en` is 1 in cycle N+1 only. Back-to-back enables are exactly 2^DIV_WIDTH cycles apart.
- **Step enable latency:** if a step press pulse occurs in cycle N in PAUSED, the state is STEP and `o_cpu_en` is 1 in cycle N+1, and the state is PAUSED in cycle N+2.
- **Press latency:** raw input first sampled high in cycle 0 → press pulse in cycle 3 without debounce, or in cycle DEBOUNCE_CYCLES+3 with debounce. One press pulse is generated per button push, regardless of hold time.
- **`i_hlt` latency:** `i_hlt` sampled high in cycle N → `o_halted` = 1 and `o_running` = 0 in N+1. A tick in cycle N produces no enable.
- **Heartbeat:** tick in N → `o_heartbeat` toggles in N+1, in every state including HALTED.
- **Debounce counter:** at least ceil(log2(DEBOUNCE_CYCLES+1)) bits wide. It saturates and does not wrap.

## Configuration
- **`CPU_CLK_CTRL_DEBOUNCE_EN` defined:**
  - Each synchronised button feeds a stability counter that resets on any level change.
  - The debounced level updates only after DEBOUNCE_CYCLES consecutive equal samples.
  - Glitches shorter than DEBOUNCE_CYCLES produce no press.
- **Not defined:**
  - The debounce logic and `DEBOUNCE_CYCLES` are unused.
  - A press is the rising edge of the 2-flop synchronised level.
  - Each bounce edge produces a separate press. This mode is intended for simulation only.

## Test plan
- **Reset:** DIV_WIDTH=4, START_RUN=1, reset held 3 cycles then released.
  - `o_cpu_en` pulses first at cycle 16 after release, then every 16 cycles.
  - `o_heartbeat` toggles at each pulse.
- **Pause/step:** in RUNNING, pulse `i_run_btn` → PAUSED with no further enables. Then push `i_step_btn` three times.
  - Exactly three single-cycle `o_cpu_en` pulses.
  - Each pulse occurs 4 cycles after its raw rise (no debounce).
- **Simultaneous presses:** in PAUSED, `i_run_btn` and `i_step_btn` rise in the same cycle → RUNNING with no STEP pulse.
- **Halt priority:** `i_hlt` high in the same cycle as a tick and a run press.
  - HALTED next cycle with no enable.
  - Subsequent buttons are ignored.
  - `o_halted` stays 1 until reset.
- **Debounce (macro defined, DEBOUNCE_CYCLES=8):**
  - A 5-cycle glitch on `i_step_btn` → no pulse.
  - A 20-cycle push → one pulse at raw rise + 11 cycles.
  - Reset asserted at debounce count 4 → no pulse.
